// File: rtl/echo_request_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// echo_pkg: EchoRequest_data message layout, tag constants and FSM states
// Revision: 1.0
// ============================================================================
package echo_pkg;

  localparam int          ECHO_WORD_W        = 32;
  localparam logic [31:0] ECHO_TAG_SAY       = 32'd1;
  localparam logic [31:0] ECHO_TAG_SAY2      = 32'd2;
  localparam logic [1:0]  ECHO_SAY_BODY_LEN  = 2'd2;
  localparam logic [1:0]  ECHO_SAY2_BODY_LEN = 2'd3;

  typedef struct packed {
    logic [ECHO_WORD_W-1:0] v;
    logic [ECHO_WORD_W-1:0] meth;
  } echo_say_t;

  typedef struct packed {
    logic [ECHO_WORD_W-1:0] v2;
    logic [ECHO_WORD_W-1:0] v;
    logic [ECHO_WORD_W-1:0] meth;
  } echo_say2_t;

  // Union members sit side by side; the unselected member stays zero.
  typedef struct packed {
    echo_say2_t say2;
    echo_say_t  say;
  } echo_request_union_t;

  typedef struct packed {
    echo_request_union_t    data;
    logic [ECHO_WORD_W-1:0] tag;
  } EchoRequest_data;

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_BODY  = 2'd1,
    ST_SEND  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  function automatic logic tag_is_valid(input logic [ECHO_WORD_W-1:0] tag);
    tag_is_valid = (tag == ECHO_TAG_SAY) || (tag == ECHO_TAG_SAY2);
  endfunction

  // Number of beats following the tag; zero for unknown tags.
  function automatic logic [1:0] body_len(input logic [ECHO_WORD_W-1:0] tag);
    case (tag)
      ECHO_TAG_SAY:  body_len = ECHO_SAY_BODY_LEN;
      ECHO_TAG_SAY2: body_len = ECHO_SAY2_BODY_LEN;
      default:       body_len = 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/echo_request_deserializer_if.sv
`default_nettype none
// ============================================================================
// echo_request_deserializer_if: beat input stream and pipe.enq output handshake
// Revision: 1.0
// ============================================================================
interface echo_request_deserializer_if;
  import echo_pkg::*;

  logic                   beat__ENA;
  logic [ECHO_WORD_W-1:0] beat_v;
  logic                   beat_last;
  logic                   beat__RDY;

  logic                   pipe_enq__ENA;
  EchoRequest_data        pipe_enq_v;
  logic                   pipe_enq__RDY;

  modport master (
    output beat__ENA,
    output beat_v,
    output beat_last,
    input  beat__RDY,
    input  pipe_enq__ENA,
    input  pipe_enq_v,
    output pipe_enq__RDY
  );

  modport slave (
    input  beat__ENA,
    input  beat_v,
    input  beat_last,
    output beat__RDY,
    output pipe_enq__ENA,
    output pipe_enq_v,
    input  pipe_enq__RDY
  );

endinterface
`default_nettype wire

// File: rtl/echo_request_deserializer.sv
`default_nettype none
// ============================================================================
// echo_request_deserializer: assembles tag+argument beats into EchoRequest_data
// and offers each well-formed message on pipe.enq; malformed frames are counted.
// Revision: 1.0
// ============================================================================
module echo_request_deserializer
  import echo_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  wire logic                   CLK,
  input  wire logic                   nRST,
  echo_request_deserializer_if.slave  io,
  output logic [ERR_W-1:0]            err_count
);

  state_t          r_state;
  state_t          w_state_next;
  logic [1:0]      r_idx;
  logic [1:0]      w_idx_next;
  EchoRequest_data r_msg;
  EchoRequest_data w_msg_next;
  logic [ERR_W-1:0] r_err_count;
  logic            w_err;
  logic            w_beat_rdy;
  logic            w_accept;
  logic            w_final;

  // Handshake outputs are pure functions of state.
  assign w_beat_rdy = (r_state != ST_SEND);
  assign w_accept   = io.beat__ENA & w_beat_rdy;
  assign w_final    = (r_idx == (body_len(r_msg.tag) - 2'd1));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_HDR;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_msg_next   = r_msg;
    w_err        = 1'b0;

    case (r_state)
      ST_HDR: begin
        if (w_accept) begin
          w_msg_next     = '0;
          w_msg_next.tag = io.beat_v;
          w_idx_next     = 2'd0;
          if (!tag_is_valid(io.beat_v) || io.beat_last) begin
            w_err        = 1'b1;
            w_state_next = io.beat_last ? ST_HDR : ST_DRAIN;
          end else begin
            w_state_next = ST_BODY;
          end
        end
      end

      ST_BODY: begin
        if (w_accept) begin
          if (r_msg.tag == ECHO_TAG_SAY) begin
            case (r_idx)
              2'd0:    w_msg_next.data.say.meth = io.beat_v;
              2'd1:    w_msg_next.data.say.v    = io.beat_v;
              default: ;
            endcase
          end else begin
            case (r_idx)
              2'd0:    w_msg_next.data.say2.meth = io.beat_v;
              2'd1:    w_msg_next.data.say2.v    = io.beat_v;
              2'd2:    w_msg_next.data.say2.v2   = io.beat_v;
              default: ;
            endcase
          end
          w_idx_next = r_idx + 2'd1;

          // Early last ends the frame here; missing last is flushed in DRAIN.
          if (io.beat_last) begin
            if (w_final) begin
              w_state_next = ST_SEND;
            end else begin
              w_err        = 1'b1;
              w_state_next = ST_HDR;
            end
          end else if (w_final) begin
            w_err        = 1'b1;
            w_state_next = ST_DRAIN;
          end
        end
      end

      ST_SEND: begin
        if (io.pipe_enq__RDY) begin
          w_state_next = ST_HDR;
          w_idx_next   = 2'd0;
        end
      end

      ST_DRAIN: begin
        if (w_accept && io.beat_last) begin
          w_state_next = ST_HDR;
        end
      end

      default: begin
        w_state_next = ST_HDR;
        w_idx_next   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_idx <= 2'd0;
      r_msg <= '0;
    end else begin
      r_idx <= w_idx_next;
      r_msg <= w_msg_next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_err_count <= '0;
    end else if (w_err && (r_err_count != {ERR_W{1'b1}})) begin
      r_err_count <= r_err_count + ERR_W'(1);
    end
  end

  assign io.beat__RDY     = w_beat_rdy;
  assign io.pipe_enq__ENA = (r_state == ST_SEND);
  assign io.pipe_enq_v    = r_msg;
  assign err_count        = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_echo_request_deserializer.sv
`default_nettype none
// ============================================================================
// tb_echo_request_deserializer: directed and random frames against a
// frame-level reference model of the deserializer.
// Revision: 1.0
// ============================================================================
module tb_echo_request_deserializer;

  localparam int WAIT_LIMIT = 200;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  echo_request_deserializer_if ifc ();
  echo_request_deserializer_if ifc_sat ();

  logic [7:0] err_count;
  logic [1:0] err_count_sat;

  echo_request_deserializer #(.ERR_W(8)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .io        (ifc.slave),
    .err_count (err_count)
  );

  // Narrow-counter instance sees the same beat stream and never stalls.
  echo_request_deserializer #(.ERR_W(2)) dut_sat (
    .CLK       (CLK),
    .nRST      (nRST),
    .io        (ifc_sat.slave),
    .err_count (err_count_sat)
  );

  assign ifc_sat.beat__ENA     = ifc.beat__ENA;
  assign ifc_sat.beat_v        = ifc.beat_v;
  assign ifc_sat.beat_last     = ifc.beat_last;
  assign ifc_sat.pipe_enq__RDY = 1'b1;

  int           checks = 0;
  int           errors = 0;
  int           sink_mode = 1;  // 0: hold low, 1: always ready, 2: random
  int           gap_max = 0;
  int           exp_err = 0;
  logic [191:0] got_q[$];
  logic [191:0] exp_q[$];
  logic [31:0]  frame_q[$];

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is everything up to and including its last beat.
  task automatic model_frame();
    int n;
    n = frame_q.size();
    if (frame_q[0] == 32'd1 && n == 3)
      exp_q.push_back({96'h0, frame_q[2], frame_q[1], frame_q[0]});
    else if (frame_q[0] == 32'd2 && n == 4)
      exp_q.push_back({frame_q[3], frame_q[2], frame_q[1], 64'h0, frame_q[0]});
    else if (exp_err < 255)
      exp_err++;
  endtask

  task automatic drive_beat(input logic [31:0] v, input logic l);
    int waited;
    waited = 0;
    ifc.beat__ENA  = 1'b1;
    ifc.beat_v     = v;
    ifc.beat_last  = l;
    while (ifc.beat__RDY !== 1'b1 && waited <= WAIT_LIMIT) begin
      @(negedge CLK);
      waited++;
    end
    check("beat_accept_wait_expired", 192'(waited > WAIT_LIMIT), 192'(0));
    @(negedge CLK);
    ifc.beat__ENA  = 1'b0;
    ifc.beat_last  = 1'b0;
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame_q.size(); i++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge CLK);
      drive_beat(frame_q[i], i == frame_q.size() - 1);
    end
    model_frame();
  endtask

  task automatic compare_queues(input string name);
    check({name, "_emit_count"}, 192'(got_q.size()), 192'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({name, "_emit_value"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // Downstream ready changes just after the rising edge.
  initial begin
    ifc.pipe_enq__RDY = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (sink_mode)
        0:       ifc.pipe_enq__RDY = 1'b0;
        1:       ifc.pipe_enq__RDY = 1'b1;
        default: ifc.pipe_enq__RDY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // A message is handed off at the edge following a negedge with ENA & RDY.
  initial begin
    forever begin
      @(negedge CLK);
      if (nRST === 1'b1 && ifc.pipe_enq__ENA === 1'b1 && ifc.pipe_enq__RDY === 1'b1)
        got_q.push_back(ifc.pipe_enq_v);
    end
  end

  initial begin
    int          kind;
    int          len;
    int          waited;
    logic [31:0] tag;

    ifc.beat__ENA = 1'b0;
    ifc.beat_v    = '0;
    ifc.beat_last = 1'b0;
    nRST          = 1'b0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;

    check("reset_enq_ena", 192'(ifc.pipe_enq__ENA), 192'(0));
    check("reset_beat_rdy", 192'(ifc.beat__RDY), 192'(1));
    check("reset_err_count", 192'(err_count), 192'(0));
    check("reset_enq_value", ifc.pipe_enq_v, 192'(0));

    // Saturation: five malformed frames of different kinds
    for (int f = 0; f < 5; f++) begin
      case (f)
        0:       frame_q = {32'd7, 32'h1, 32'h2};
        1:       frame_q = {32'd1};
        2:       frame_q = {32'd2, 32'hB, 32'h11};
        3:       frame_q = {32'd1, 32'hA, 32'h55, 32'h66};
        default: frame_q = {32'd0};
      endcase
      send_frame();
      check("sat_err_count", 192'(err_count_sat), 192'((exp_err > 3) ? 3 : exp_err));
    end
    check("sat_wide_err_count", 192'(err_count), 192'(exp_err));
    compare_queues("sat");

    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    exp_err = 0;
    got_q.delete();
    exp_q.delete();

    // Say frame with a ready sink
    frame_q = {32'd1, 32'hA, 32'h55};
    send_frame();
    check("say_latency_ena", 192'(ifc.pipe_enq__ENA), 192'(1));
    check("say_value", ifc.pipe_enq_v, {96'h0, 32'h55, 32'hA, 32'd1});
    @(negedge CLK);
    check("say_single_ena_cycle", 192'(ifc.pipe_enq__ENA), 192'(0));
    check("say_err_count", 192'(err_count), 192'(exp_err));
    compare_queues("say");

    // Say2 frame with downstream stalled for five cycles
    sink_mode = 0;
    @(negedge CLK);
    frame_q = {32'd2, 32'hB, 32'h11, 32'h22};
    send_frame();
    for (int i = 0; i < 6; i++) begin
      check("say2_hold_ena", 192'(ifc.pipe_enq__ENA), 192'(1));
      check("say2_hold_value", ifc.pipe_enq_v, {32'h22, 32'h11, 32'hB, 64'h0, 32'd2});
      check("say2_hold_beat_rdy", 192'(ifc.beat__RDY), 192'(0));
      if (i == 0) begin
        ifc.beat__ENA = 1'b1;
        ifc.beat_v    = 32'd1;
        ifc.beat_last = 1'b0;
      end
      if (i == 4) begin
        sink_mode     = 1;
        ifc.beat__ENA = 1'b0;
      end
      @(negedge CLK);
    end
    check("say2_after_handoff_ena", 192'(ifc.pipe_enq__ENA), 192'(0));
    check("say2_after_handoff_beat_rdy", 192'(ifc.beat__RDY), 192'(1));
    compare_queues("say2");

    // Bad tag followed by a valid say frame
    frame_q = {32'd7, 32'h1, 32'h2};
    send_frame();
    check("bad_tag_err_count", 192'(err_count), 192'(exp_err));
    frame_q = {32'd1, 32'hC, 32'h77};
    send_frame();
    @(negedge CLK);
    compare_queues("bad_tag");

    // Early last, then an overlong frame, then a valid frame
    frame_q = {32'd2, 32'hB, 32'h11};
    send_frame();
    check("early_last_err_count", 192'(err_count), 192'(exp_err));
    frame_q = {32'd1, 32'hA, 32'h55, 32'h66};
    send_frame();
    check("overlong_err_count", 192'(err_count), 192'(exp_err));
    frame_q = {32'd1, 32'hD, 32'h99};
    send_frame();
    @(negedge CLK);
    compare_queues("length");

    // Random frames with random gaps and a random sink
    gap_max   = 2;
    sink_mode = 2;
    for (int f = 0; f < 60; f++) begin
      frame_q.delete();
      kind = $urandom_range(0, 5);
      if (kind <= 1) begin
        tag = 32'd1;
        len = 3;
      end else if (kind <= 3) begin
        tag = 32'd2;
        len = 4;
      end else if (kind == 4) begin
        tag = $urandom_range(3, 1000);
        if ($urandom_range(0, 3) == 0) tag = 32'd0;
        len = $urandom_range(1, 4);
      end else begin
        tag = $urandom_range(1, 2);
        len = $urandom_range(1, 5);
        if (len == int'(tag) + 2) len++;
      end
      frame_q.push_back(tag);
      for (int b = 1; b < len; b++) frame_q.push_back($urandom());
      send_frame();
    end
    sink_mode = 1;
    gap_max   = 0;
    waited    = 0;
    while (ifc.pipe_enq__ENA !== 1'b0 && waited <= WAIT_LIMIT) begin
      @(negedge CLK);
      waited++;
    end
    check("random_drain_wait_expired", 192'(waited > WAIT_LIMIT), 192'(0));
    @(negedge CLK);
    compare_queues("random");
    check("random_err_count", 192'(err_count), 192'(exp_err));

    // Asynchronous reset while a message is waiting in SEND
    sink_mode = 0;
    @(negedge CLK);
    frame_q = {32'd1, 32'hE, 32'h3};
    send_frame();
    check("pre_reset_enq_ena", 192'(ifc.pipe_enq__ENA), 192'(1));
    #2;
    nRST = 1'b0;
    #1;
    check("async_reset_enq_ena", 192'(ifc.pipe_enq__ENA), 192'(0));
    check("async_reset_beat_rdy", 192'(ifc.beat__RDY), 192'(1));
    check("async_reset_err_count", 192'(err_count), 192'(0));
    check("async_reset_enq_value", ifc.pipe_enq_v, 192'(0));
    exp_q.delete();
    exp_err = 0;
    @(negedge CLK);
    nRST      = 1'b1;
    sink_mode = 1;
    @(negedge CLK);
    frame_q = {32'd1, 32'hF, 32'h44};
    send_frame();
    @(negedge CLK);
    compare_queues("post_reset");
    check("post_reset_err_count", 192'(err_count), 192'(exp_err));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
